load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, SHALL set the maximum number of mem_req cycles without mem_ack before a transaction aborts; range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  launch a transaction; sampled only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load; sampled with start.
REQ-006 funct3  input  3  access size and sign: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-007 addr  input  32  byte address, taken from the ALU Result of the same instruction.
REQ-008 store_data  input  32  rs2 value; data in the low bytes.
REQ-009 mem_req  output  1  memory request, held high until mem_ack or timeout.
REQ-010 mem_we  output  1  write enable, qualified by mem_req.
REQ-011 mem_addr  output  32  word address: latched addr[31:2] followed by 2'b00.
REQ-012 mem_wdata  output  32  lane-aligned store data.
REQ-013 mem_wmask  output  4  byte-lane enables; 4'b0000 on loads.
REQ-014 mem_rdata  input  32  read word, valid in the mem_ack cycle.
REQ-015 mem_ack  input  1  memory completion; ignored unless the FSM is in REQ.
REQ-016 busy  output  1  high in REQ and DONE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err  output  1  valid with done; misaligned access, illegal funct3, or timeout.
REQ-019 load_data  output  32  extended load result; holds until the next load completes.

Function
REQ-020 The FSM SHALL have three states, IDLE, REQ and DONE; done is high only in DONE, and DONE always returns to IDLE on the next cycle.
REQ-021 In IDLE, start SHALL latch is_store, funct3, addr and store_data, and SHALL move to REQ next cycle when the access is legal.
REQ-022 In IDLE, start with an illegal access SHALL move to DONE with err=1 and issue no mem_req.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Illegal funct3: any encoding not listed in REQ-006, and on stores funct3 of 100 or 101.
REQ-023 Start while busy SHALL be ignored; no queueing.
REQ-024 In REQ, mem_req SHALL be 1 and mem_addr, mem_we, mem_wdata and mem_wmask SHALL be stable until exit.
REQ-025 In REQ, mem_ack SHALL move the FSM to DONE with err=0; on loads, load_data SHALL be captured from mem_rdata in that cycle.
REQ-026 A cycle counter SHALL clear on entry to REQ; when ACK_TIMEOUT REQ cycles elapse without mem_ack, the FSM SHALL go to DONE with err=1 and load_data unchanged.
REQ-027 If mem_ack and the timeout occur in the same cycle, mem_ack SHALL win.
REQ-028 Latency SHALL be: start at cycle 0, mem_req from cycle 1, mem_ack at cycle k>=1, done at cycle k+1; an illegal access gives done at cycle 1.
REQ-029 Store lanes:
- SB: wdata = byte replicated x4; wmask = 4'b0001 shifted left by addr[1:0].
- SH: wdata = half replicated x2; wmask = 4'b0011 shifted left by addr[1:0].
- SW: wdata = store_data; wmask = 4'b1111.
REQ-030 Load extract: select the byte or half at addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

Reset
REQ-031 Reset SHALL put the FSM in IDLE and clear the counter.
REQ-032 Reset SHALL drive mem_req, mem_we, mem_wmask, done, err and busy to 0, and clear load_data, mem_addr and mem_wdata to 32'h0.
REQ-033 Reset asserted in REQ SHALL drop mem_req on the next edge; a mem_ack arriving after reset SHALL be ignored.

Structure
REQ-034 Shared package lsu_pkg SHALL hold the state enum and the funct3 load/store constants, shared with the decoder.
REQ-035 Combinational lane insert/extract SHALL live in sub-module lsu_align; the FSM, counter and registers SHALL stay in load_store_unit.

Verification
REQ-036 LW at addr 0x100, mem_rdata 0xDEADBEEF, ack after 3 cycles -> mem_addr 0x100, done at cycle 4, load_data 0xDEADBEEF, err 0.
REQ-037 LB at 0x103 and LBU at 0x103, mem_rdata 0x80FF_0000 -> load_data 0xFFFFFF80 for LB, 0x00000080 for LBU.
REQ-038 SH at 0x202, store_data 0x1234ABCD -> mem_wdata 0xABCDABCD, mem_wmask 4'b1100, mem_we 1.
REQ-039 LH at 0x101 -> done with err 1 at cycle 1, mem_req never asserted.
REQ-040 ACK_TIMEOUT=4, no mem_ack -> mem_req high exactly 4 cycles, then done with err 1; mem_ack plus start arriving while busy -> ignored.
REQ-041 Reset asserted in REQ -> mem_req 0 next cycle, no done pulse, and the next transaction completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit and its decoder.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/lsu_if.sv
// Word-addressed memory port between the load/store unit (master) and memory (slave).
interface lsu_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane insert for stores, legality check, and load extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        st_is_store,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] store_data,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic        illegal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [3:0]  mask_s;
  logic [31:0] shifted_s;

  // Store lane replication, lane mask and access legality for the request being launched.
  always_comb begin
    wdata   = 32'h0000_0000;
    mask_s  = 4'b0000;
    illegal = 1'b0;
    case (st_funct3)
      F3_LB: begin
        wdata  = {4{store_data[7:0]}};
        mask_s = 4'b0001 << st_addr_lo;
      end
      F3_LH: begin
        wdata   = {2{store_data[15:0]}};
        mask_s  = 4'b0011 << st_addr_lo;
        illegal = st_addr_lo[0];
      end
      F3_LW: begin
        wdata   = store_data;
        mask_s  = 4'b1111;
        illegal = (st_addr_lo != 2'b00);
      end
      F3_LBU: illegal = st_is_store;
      F3_LHU: illegal = st_is_store | st_addr_lo[0];
      default: illegal = 1'b1;
    endcase
    if (st_is_store) begin
      wmask = mask_s;
    end else begin
      wmask = 4'b0000;
    end
  end

  // Legal words are always aligned, so the shifted value doubles as the word pass-through.
  assign shifted_s = rdata >> {ld_addr_lo, 3'b000};

  // Sign or zero extension of the selected byte/half of the returned word.
  always_comb begin
    load_data = shifted_s;
    case (ld_funct3)
      F3_LB:   load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LH:   load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LW:   load_data = shifted_s;
      F3_LBU:  load_data = {24'h00_0000, shifted_s[7:0]};
      F3_LHU:  load_data = {16'h0000, shifted_s[15:0]};
      default: load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE/REQ/DONE sequencer with ack timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  lsu_if.master       mem,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 32'd1);

  lsu_state_e       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic             is_store_r;
  logic [2:0]       funct3_r;
  logic [1:0]       addr_lo_r;
  logic [31:0]      mem_addr_r, mem_wdata_r, load_data_r;
  logic [3:0]       mem_wmask_r;
  logic             mem_we_r, err_r;

  logic [31:0] wdata_s, ld_s;
  logic [3:0]  wmask_s;
  logic        illegal_s, timeout_s, launch_s, finish_s;

  lsu_align u_align (
    .st_is_store (is_store),
    .st_funct3   (funct3),
    .st_addr_lo  (addr[1:0]),
    .store_data  (store_data),
    .wdata       (wdata_s),
    .wmask       (wmask_s),
    .illegal     (illegal_s),
    .ld_funct3   (funct3_r),
    .ld_addr_lo  (addr_lo_r),
    .rdata       (mem.mem_rdata),
    .load_data   (ld_s)
  );

  assign timeout_s = (cnt_r == CNT_LAST);
  assign launch_s  = (state_r == ST_IDLE) && start;
  assign finish_s  = (state_r == ST_REQ) && (mem.mem_ack || timeout_s);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; ack is tested before the timeout so it wins a tie.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = illegal_s ? ST_DONE : ST_REQ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          state_nx_s = ST_DONE;
        end else if (timeout_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem.mem_req = 1'b0;
    case (state_r)
      ST_IDLE: busy = 1'b0;
      ST_REQ: begin
        busy        = 1'b1;
        mem.mem_req = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // REQ cycle counter, held at zero outside REQ so it is clear on every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (state_r != ST_REQ) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Request latch at launch, completion status and load capture at exit from REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_r  <= 1'b0;
      funct3_r    <= 3'b000;
      addr_lo_r   <= 2'b00;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_wmask_r <= 4'b0000;
      mem_we_r    <= 1'b0;
      err_r       <= 1'b0;
      load_data_r <= 32'h0000_0000;
    end else if (launch_s) begin
      is_store_r  <= is_store;
      funct3_r    <= funct3;
      addr_lo_r   <= addr[1:0];
      mem_addr_r  <= {addr[31:2], 2'b00};
      mem_wdata_r <= wdata_s;
      mem_wmask_r <= wmask_s;
      mem_we_r    <= is_store & ~illegal_s;
      err_r       <= illegal_s;
    end else if (finish_s) begin
      mem_we_r <= 1'b0;
      err_r    <= ~mem.mem_ack;
      if (mem.mem_ack && !is_store_r) begin
        load_data_r <= ld_s;
      end
    end else if (state_r == ST_DONE) begin
      err_r <= 1'b0;
    end
  end

  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign mem.mem_wmask = mem_wmask_r;
  assign err           = err_r;
  assign load_data     = load_data_r;

endmodule
